// File: rtl/vga_frame_monitor_pkg.sv
// Shared constants, types and helpers for the VGA frame timing monitor.
package vga_frame_monitor_pkg;

  localparam int CNT_W = 16;

  localparam logic [5:0] ADDR_CTRL      = 6'h00;
  localparam logic [5:0] ADDR_STATUS    = 6'h04;
  localparam logic [5:0] ADDR_H_TOTAL   = 6'h08;
  localparam logic [5:0] ADDR_H_SYNC    = 6'h0C;
  localparam logic [5:0] ADDR_V_TOTAL   = 6'h10;
  localparam logic [5:0] ADDR_V_SYNC    = 6'h14;
  localparam logic [5:0] ADDR_CHECKSUM  = 6'h18;
  localparam logic [5:0] ADDR_FRAME_CNT = 6'h1C;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_POL    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_FRAME_DONE = 0;
  localparam int ST_LOCKED     = 1;
  localparam int ST_OVF        = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    MEASURE = 2'd2
  } state_t;

  // One frame's worth of measurements; used for both working and latched copies.
  typedef struct packed {
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_sync;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_sync;
    logic [31:0]      checksum;
  } frame_res_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_frame_monitor_if.sv
// Register bus between a host and the frame monitor.
interface vga_frame_monitor_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/vga_sync_edge.sv
// Polarity-normalizes one sync line and flags its leading (inactive->active) edge.
module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sync,
  input  logic pol,
  output logic active,
  output logic lead
);
  logic prev;

  assign active = sync ~^ pol;
  assign lead   = active & ~prev;

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= active;
  end
endmodule

// File: rtl/vga_frame_monitor.sv
// Measures VGA sync timing and a pixel checksum per frame, exposed over a register bus.
module vga_frame_monitor
  import vga_frame_monitor_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          ui_in,
  output logic [7:0]          uo_out,
  vga_frame_monitor_if.slave  bus,
  output logic                user_interrupt
);

  logic [7:0]       ui_q;
  logic [1:0]       act, lead;
  logic             hs_act, hs_lead, vs_act, vs_lead;
  logic [2:0]       ctrl;
  logic             frame_done, locked, ovf;
  logic             have_prev;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] h_cnt;
  frame_res_t       wrk, res;
  state_t           state, state_nxt;
  logic             wr, wr_status, meas, latch, ovf_hit;
  logic             unused;

  assign uo_out         = '0;
  assign bus.data_ready = 1'b1;
  assign unused         = &{1'b0, bus.data_read_n, bus.data_in[31:3]};

  always_ff @(posedge clk) begin
    if (!rst_n) ui_q <= '0;
    else        ui_q <= ui_in;
  end

  // index 0 = hsync (bit 6), index 1 = vsync (bit 7)
  for (genvar i = 0; i < 2; i++) begin : g_sync
    vga_sync_edge u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .sync   (ui_q[6+i]),
      .pol    (ctrl[CTRL_POL]),
      .active (act[i]),
      .lead   (lead[i])
    );
  end

  assign hs_act  = act[0];
  assign hs_lead = lead[0];
  assign vs_act  = act[1];
  assign vs_lead = lead[1];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!ctrl[CTRL_EN]) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = WAIT_VS;
        WAIT_VS: if (vs_lead) state_nxt = MEASURE;
        MEASURE: state_nxt = MEASURE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign meas  = (state == MEASURE) && ctrl[CTRL_EN];
  assign latch = meas && vs_lead;

  // A counter already at full scale that would step again this cycle.
  assign ovf_hit = meas && !vs_lead &&
                   (hs_lead ? ((&wrk.v_total) || (vs_act && (&wrk.v_sync)))
                            : ((&h_cnt) || (hs_act && (&wrk.h_sync))));

  // Working counters live only while measuring; a vsync edge starts a fresh frame.
  always_ff @(posedge clk) begin
    if (!rst_n || !meas || vs_lead) begin
      h_cnt <= '0;
      wrk   <= '0;
    end else begin
      if (hs_lead) begin
        wrk.h_total <= h_cnt;
        h_cnt       <= CNT_W'(1);
        wrk.h_sync  <= CNT_W'(1);
        wrk.v_total <= sat_inc(wrk.v_total);
        if (vs_act) wrk.v_sync <= sat_inc(wrk.v_sync);
      end else begin
        h_cnt <= sat_inc(h_cnt);
        if (hs_act) wrk.h_sync <= sat_inc(wrk.h_sync);
      end
      if (!hs_act && !vs_act)
        wrk.checksum <= {wrk.checksum[30:0], wrk.checksum[31]} ^ {26'b0, ui_q[5:0]};
    end
  end

  assign wr        = (bus.data_write_n != 2'b11);
  assign wr_status = wr && (bus.address == ADDR_STATUS);

  // Sticky bits: the software clear comes first so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl       <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      ovf        <= 1'b0;
      have_prev  <= 1'b0;
      frame_cnt  <= '0;
      res        <= '0;
    end else begin
      if (wr && (bus.address == ADDR_CTRL)) ctrl <= bus.data_in[2:0];
      if (wr_status && bus.data_in[ST_FRAME_DONE]) frame_done <= 1'b0;
      if (wr_status && bus.data_in[ST_OVF])        ovf        <= 1'b0;
      if (ovf_hit) ovf <= 1'b1;
      if (latch) begin
        res        <= wrk;
        frame_cnt  <= frame_cnt + 1'b1;
        frame_done <= 1'b1;
        have_prev  <= 1'b1;
        locked     <= have_prev && (wrk.h_total == res.h_total) &&
                      (wrk.v_total == res.v_total);
      end else if ((state == MEASURE) && (state_nxt != MEASURE)) begin
        locked <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.data_out = '0;
    case (bus.address)
      ADDR_CTRL:      bus.data_out = {29'b0, ctrl};
      ADDR_STATUS:    bus.data_out = {29'b0, ovf, locked, frame_done};
      ADDR_H_TOTAL:   bus.data_out = {16'b0, res.h_total};
      ADDR_H_SYNC:    bus.data_out = {16'b0, res.h_sync};
      ADDR_V_TOTAL:   bus.data_out = {16'b0, res.v_total};
      ADDR_V_SYNC:    bus.data_out = {16'b0, res.v_sync};
      ADDR_CHECKSUM:  bus.data_out = res.checksum;
      ADDR_FRAME_CNT: bus.data_out = {16'b0, frame_cnt};
      default:        bus.data_out = '0;
    endcase
  end

  assign user_interrupt = frame_done & ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench: reads queue an expectation, a negedge monitor pops and compares.
module tb_vga_frame_monitor;
  import vga_frame_monitor_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = '0;
  logic [7:0] uo_out;
  logic       user_interrupt;

  vga_frame_monitor_if bus();

  vga_frame_monitor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .bus            (bus),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] K_REG = 2'd0, K_IRQ = 2'd1, K_UO = 2'd2, K_ST = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // stream model state
  logic        neg = 1'b0;
  logic [31:0] acc_m = '0;
  logic [31:0] cs_m = '0;
  logic        vs_prev_m = 1'b0;

  exp_t        m_e;
  string       m_nm;
  logic [31:0] m_act;

  always @(negedge clk) begin
    if (bus.data_read_n != 2'b11) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got a read with no expectation queued");
      end else begin
        m_e  = exp_q.pop_front();
        m_nm = name_q.pop_front();
        case (m_e.kind)
          K_REG:   m_act = bus.data_out;
          K_IRQ:   m_act = {31'b0, user_interrupt};
          K_UO:    m_act = {23'b0, bus.data_ready, uo_out};
          default: m_act = 32'(dut.state);
        endcase
        if (m_act !== m_e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", m_nm, m_act, m_e.val);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [1:0] kind, input logic [5:0] addr,
                     input logic [31:0] val, input string nm);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
    name_q.push_back(nm);
    bus.address     = addr;
    bus.data_read_n = 2'b00;
    tick();
    bus.data_read_n = 2'b11;
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] d, input logic [1:0] w);
    bus.address      = addr;
    bus.data_in      = d;
    bus.data_write_n = w;
    tick();
    bus.data_write_n = 2'b11;
  endtask

  // One sample per clock; the model folds pixels and captures the checksum at each vsync edge.
  task automatic sample(input logic hs, input logic vs, input logic [5:0] pix);
    ui_in = {vs ^ neg, hs ^ neg, pix};
    if (!hs && !vs) acc_m = {acc_m[30:0], acc_m[31]} ^ {26'b0, pix};
    if (vs && !vs_prev_m) begin
      cs_m  = acc_m;
      acc_m = '0;
    end
    vs_prev_m = vs;
    tick();
  endtask

  // Frame = 10 lines x 20 clocks; hsync pos 0..2; vsync from idx 5 to idx 44.
  task automatic seg(input int from, input int to, input logic [5:0] pix,
                     input int alt_idx, input logic [5:0] alt);
    for (int i = from; i <= to; i++)
      sample((i % 20) < 3, (i >= 5) && (i < 45), (i == alt_idx) ? alt : pix);
  endtask

  task automatic vs_edge(input logic [5:0] pix);
    seg(0, 5, pix, -1, 6'h00);
  endtask

  task automatic body(input logic [5:0] pix, input int alt_idx, input logic [5:0] alt);
    seg(6, 199, pix, alt_idx, alt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sample(1'b0, 1'b0, 6'h00);
  endtask

  task automatic do_reset(input logic n);
    neg       = n;
    rst_n     = 1'b0;
    ui_in     = {n, n, 6'h00};
    vs_prev_m = 1'b0;
    acc_m     = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.address      = '0;
    bus.data_in      = '0;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;
    do_reset(1'b0);

    chk(K_REG, ADDR_CTRL,      32'h0, "rst_ctrl");
    chk(K_REG, ADDR_STATUS,    32'h0, "rst_status");
    chk(K_REG, ADDR_FRAME_CNT, 32'h0, "rst_frame_cnt");
    chk(K_IRQ, 6'h00,          32'h0, "rst_irq");
    chk(K_UO,  6'h00,          32'h100, "uo_zero_ready_one");
    chk(K_ST,  6'h00,          32'(IDLE), "rst_state");
    wr(ADDR_H_TOTAL, 32'h0000_FFFF, 2'b10);
    chk(K_REG, ADDR_H_TOTAL,   32'h0, "ro_write_ignored");
    chk(K_REG, 6'h20,          32'h0, "undecoded_reads_zero");

    // positive polarity, nominal timing
    wr(ADDR_CTRL, 32'h7, 2'b00);
    tick();
    chk(K_ST, 6'h00, 32'(WAIT_VS), "state_wait_vs");
    vs_edge(6'h3F);
    body(6'h3F, -1, 6'h00);
    vs_edge(6'h3F);
    chk(K_REG, ADDR_FRAME_CNT, 32'd0, "latency_not_yet");
    chk(K_REG, ADDR_H_TOTAL,   32'd20, "pos_h_total");
    chk(K_REG, ADDR_H_SYNC,    32'd3,  "pos_h_sync");
    chk(K_REG, ADDR_V_TOTAL,   32'd10, "pos_v_total");
    chk(K_REG, ADDR_V_SYNC,    32'd2,  "pos_v_sync");
    chk(K_REG, ADDR_FRAME_CNT, 32'd1,  "pos_frame_cnt");
    chk(K_REG, ADDR_STATUS,    32'h1,  "pos_status_done");
    chk(K_REG, ADDR_CHECKSUM,  cs_m,   "pos_checksum");
    chk(K_IRQ, 6'h00,          32'h1,  "irq_rises");
    wr(ADDR_STATUS, 32'h1, 2'b00);
    chk(K_REG, ADDR_STATUS,    32'h0,  "done_cleared");
    chk(K_IRQ, 6'h00,          32'h0,  "irq_dropped");

    body(6'h3F, -1, 6'h00);
    vs_edge(6'h3F);
    tick();
    chk(K_REG, ADDR_STATUS,    32'h3,  "locked_3rd_edge");
    chk(K_REG, ADDR_FRAME_CNT, 32'd2,  "frame_cnt_2");
    chk(K_REG, ADDR_CHECKSUM,  cs_m,   "checksum_frame2");
    wr(ADDR_STATUS, 32'h1, 2'b01);
    chk(K_REG, ADDR_STATUS,    32'h2,  "locked_only");

    // one pixel differs; software clear lands on the latch cycle
    body(6'h3F, 110, 6'h00);
    vs_edge(6'h3F);
    wr(ADDR_STATUS, 32'h1, 2'b10);
    chk(K_REG, ADDR_STATUS,    32'h3,  "set_beats_clear");
    chk(K_IRQ, 6'h00,          32'h1,  "irq_after_set_win");
    chk(K_REG, ADDR_CHECKSUM,  cs_m,   "checksum_changed_pixel");
    chk(K_REG, ADDR_FRAME_CNT, 32'd3,  "frame_cnt_3");

    // disable mid-frame
    seg(6, 105, 6'h3F, -1, 6'h00);
    wr(ADDR_CTRL, 32'h6, 2'b00);
    tick();
    chk(K_ST,  6'h00,          32'(IDLE), "disable_idle");
    chk(K_REG, ADDR_STATUS,    32'h1,  "disable_unlocked");
    chk(K_REG, ADDR_H_TOTAL,   32'd20, "disable_keeps_h_total");
    chk(K_REG, ADDR_CHECKSUM,  cs_m,   "disable_keeps_checksum");
    chk(K_REG, ADDR_FRAME_CNT, 32'd3,  "disable_keeps_frame_cnt");

    // negative polarity, then reset mid-frame
    do_reset(1'b1);
    wr(ADDR_CTRL, 32'h5, 2'b00);
    tick();
    vs_edge(6'h15);
    body(6'h15, -1, 6'h00);
    vs_edge(6'h15);
    tick();
    chk(K_REG, ADDR_H_TOTAL,   32'd20, "neg_h_total");
    chk(K_REG, ADDR_H_SYNC,    32'd3,  "neg_h_sync");
    chk(K_REG, ADDR_V_TOTAL,   32'd10, "neg_v_total");
    chk(K_REG, ADDR_V_SYNC,    32'd2,  "neg_v_sync");
    chk(K_REG, ADDR_FRAME_CNT, 32'd1,  "neg_frame_cnt");
    chk(K_REG, ADDR_STATUS,    32'h1,  "neg_status");
    chk(K_REG, ADDR_CHECKSUM,  cs_m,   "neg_checksum");
    chk(K_IRQ, 6'h00,          32'h1,  "neg_irq");
    seg(6, 105, 6'h15, -1, 6'h00);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk(K_REG, ADDR_CTRL,      32'h0,  "midrst_ctrl");
    chk(K_REG, ADDR_STATUS,    32'h0,  "midrst_status");
    chk(K_REG, ADDR_H_TOTAL,   32'h0,  "midrst_h_total");
    chk(K_REG, ADDR_H_SYNC,    32'h0,  "midrst_h_sync");
    chk(K_REG, ADDR_V_TOTAL,   32'h0,  "midrst_v_total");
    chk(K_REG, ADDR_V_SYNC,    32'h0,  "midrst_v_sync");
    chk(K_REG, ADDR_CHECKSUM,  32'h0,  "midrst_checksum");
    chk(K_REG, ADDR_FRAME_CNT, 32'h0,  "midrst_frame_cnt");
    chk(K_IRQ, 6'h00,          32'h0,  "midrst_irq");
    chk(K_ST,  6'h00,          32'(IDLE), "midrst_state");

    // hsync held off long enough to saturate the line counter
    do_reset(1'b0);
    wr(ADDR_CTRL, 32'h3, 2'b00);
    tick();
    vs_edge(6'h00);
    idle(70000);
    chk(K_REG, ADDR_STATUS,    32'h4,  "ovf_set");
    vs_edge(6'h00);
    tick();
    chk(K_REG, ADDR_H_TOTAL,   32'hFFFF, "ovf_h_total_saturated");
    chk(K_REG, ADDR_H_SYNC,    32'd3,  "ovf_h_sync");
    chk(K_REG, ADDR_V_TOTAL,   32'd1,  "ovf_v_total");
    chk(K_REG, ADDR_V_SYNC,    32'd0,  "ovf_v_sync");
    chk(K_REG, ADDR_STATUS,    32'h5,  "ovf_status_done");
    wr(ADDR_STATUS, 32'h4, 2'b10);
    chk(K_REG, ADDR_STATUS,    32'h1,  "ovf_cleared");

    tick();
    tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_checks: %0d left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
